accum_ctrl: RTL and testbench

ACCUM_CTRL -- requirements
Module: accum_ctrl

---
 rtl/accum_pkg.sv | 25 ++
 rtl/accum_skew.sv | 31 +++
 rtl/accum_ctrl.sv | 143 ++++++++++++++
 tb/tb_accum_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator controller.
// Parameter defaults, command encoding and FSM states.
package accum_pkg;

  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;
  localparam int DEF_SYS_ARR_COLS = 16;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_ACCUM = 2'd1,
    OP_DRAIN = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/accum_skew.sv
// Tapped shift register matching systolic column skew.
// taps[0] is the input, taps[i] the input delayed i cycles.
module accum_skew
  import accum_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            d,
  output logic [DEPTH:0][WIDTH-1:0]   taps
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  // Shift every cycle; reset flushes all stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign taps = {sr, d};

endmodule

// File: rtl/accum_ctrl.sv
// Accumulator controller: clear, skewed accumulate, drain.
// Column 0 timing is generated here; other columns via accum_skew.
module accum_ctrl
  import accum_pkg::*;
#(
  parameter int MAX_OUT_ROWS   = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS   = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_COLS   = DEF_SYS_ARR_COLS,
  parameter int NUM_ACCUM_ROWS =
    MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  parameter int ADDR_W = $clog2(NUM_ACCUM_ROWS),
  parameter int ROW_W  = $clog2(MAX_OUT_ROWS) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     op,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ROW_W-1:0]               num_rows,
  input  logic                           sa_valid,
  input  logic                           drain_ready,
  output logic                           ready,
  output logic                           done,
  output logic                           accum_clear,
  output logic [SYS_ARR_COLS-1:0]        wr_en,
  output logic [SYS_ARR_COLS*ADDR_W-1:0] wr_addr,
  output logic                           rd_en,
  output logic [ADDR_W-1:0]              rd_addr,
  output logic                           out_valid,
  output logic [ROW_W-2:0]               out_row
);

  localparam int SKEW = SYS_ARR_COLS - 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [ROW_W-1:0]    rows_q;
  logic [ROW_W-1:0]    r_q, r_d;
  logic                wr0;
  logic [ADDR_W-1:0]   wa0;
  logic [SKEW:0][ADDR_W:0] taps;

  // State, row counter, latched command and read tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      base_q    <= '0;
      rows_q    <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      out_valid <= rd_en;
      if (rd_en) out_row <= r_q[ROW_W-2:0];
      if (start && state_q == S_IDLE) begin
        base_q <= base_addr;
        rows_q <= num_rows;
      end
    end
  end

  // Next state, counter and column-0 / read strobes.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    ready       = 1'b0;
    done        = 1'b0;
    accum_clear = 1'b0;
    wr0         = 1'b0;
    wa0         = '0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        r_d   = '0;
        if (start) begin
          unique case (op_e'(op))
            OP_CLEAR: state_d = S_CLEAR;
            OP_ACCUM: state_d =
              (num_rows == '0) ? S_DONE : S_ACCUM;
            OP_DRAIN: state_d =
              (num_rows == '0) ? S_DONE : S_DRAIN;
            default:  state_d = S_DONE;
          endcase
        end
      end
      S_CLEAR: begin
        accum_clear = 1'b1;
        state_d     = S_DONE;
      end
      S_ACCUM: begin
        if (sa_valid && r_q < rows_q) begin
          wr0 = 1'b1;
          wa0 = base_q + ADDR_W'(r_q);
          r_d = r_q + 1'b1;
          if (r_q + 1'b1 == rows_q) begin
            r_d     = '0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        r_d = r_q + 1'b1;
        if (r_q == ROW_W'(SKEW - 1)) begin
          r_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (drain_ready && r_q < rows_q) begin
          rd_en   = 1'b1;
          rd_addr = base_q + ADDR_W'(r_q);
          r_d     = r_q + 1'b1;
          if (r_q + 1'b1 == rows_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  accum_skew #(
    .DEPTH (SKEW),
    .WIDTH (ADDR_W + 1)
  ) u_skew (
    .clk   (clk),
    .reset (reset),
    .d     ({wr0, wa0}),
    .taps  (taps)
  );

  for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_col
    assign wr_en[c] = taps[c][ADDR_W];
    assign wr_addr[c*ADDR_W +: ADDR_W] = taps[c][ADDR_W-1:0];
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Self-checking bench for accum_ctrl.
// Command table plus scoreboard of expected writes/reads.
module tb_accum_ctrl;
  import accum_pkg::*;

  localparam int NC  = 16;
  localparam int AW  = 10;
  localparam int RW  = 8;
  localparam int NAR = 1024;

  logic clk, reset, start, sa_valid, drain_ready;
  logic [1:0] op;
  logic [AW-1:0] base_addr;
  logic [RW-1:0] num_rows;
  logic ready, done, accum_clear, rd_en, out_valid;
  logic [NC-1:0] wr_en;
  logic [NC*AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [RW-2:0] out_row;

  accum_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .base_addr   (base_addr),
    .num_rows    (num_rows),
    .sa_valid    (sa_valid),
    .drain_ready (drain_ready),
    .ready       (ready),
    .done        (done),
    .accum_clear (accum_clear),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .out_valid   (out_valid),
    .out_row     (out_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  typedef struct {
    logic [1:0]  op;
    int          base;
    int          rows;
    logic [31:0] pat;
    int          lat;
    bit          busy;
  } vec_t;

  ev_t wq[NC][$];
  ev_t rq[$];
  ev_t oq[$];
  int  clrq[$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b1;

  task automatic chk(input string nm, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cyc %0d",
             nm, cyc);
  endtask

  function automatic int pending();
    int n;
    n = rq.size() + oq.size() + clrq.size();
    for (int c = 0; c < NC; c++) n += wq[c].size();
    return n;
  endfunction

  // Scoreboard monitor: every DUT event must match a queued one.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      for (int c = 0; c < NC; c++) begin
        if (wr_en[c]) begin
          if (wq[c].size() == 0) begin
            unexp($sformatf("wr_col%0d", c));
          end else begin
            e = wq[c].pop_front();
            chk($sformatf("wr_cyc_col%0d", c), cyc, e.cyc);
            chk($sformatf("wr_addr_col%0d", c),
                int'(wr_addr[c*AW +: AW]), e.val);
          end
        end
      end
      if (rd_en) begin
        if (rq.size() == 0) unexp("rd");
        else begin
          e = rq.pop_front();
          chk("rd_cyc", cyc, e.cyc);
          chk("rd_addr", int'(rd_addr), e.val);
        end
      end
      if (out_valid) begin
        if (oq.size() == 0) unexp("out_valid");
        else begin
          e = oq.pop_front();
          chk("out_cyc", cyc, e.cyc);
          chk("out_row", int'(out_row), e.val);
        end
      end
      if (accum_clear) begin
        if (clrq.size() == 0) unexp("accum_clear");
        else chk("clr_cyc", cyc, clrq.pop_front());
        chk("clr_excl", int'(rd_en || (|wr_en)), 0);
      end
    end
  end

  task automatic run_cmd(input vec_t v, input int idx);
    int s, r, got;
    bit b;
    ev_t e;
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1;
    op = v.op;
    base_addr = AW'(v.base);
    num_rows = RW'(v.rows);
    sa_valid = 1'b0;
    drain_ready = 1'b0;
    if (v.op == OP_CLEAR) clrq.push_back(s + 1);
    @(negedge clk);
    chk($sformatf("ready_idle_v%0d", idx), int'(ready), 1);
    r = 0;
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      @(posedge clk); #1;
      b = v.pat[i % 32];
      start = v.busy && i == 1;
      if (start) begin
        op = OP_CLEAR;
        base_addr = AW'(7);
        num_rows = RW'(9);
      end
      sa_valid = b;
      drain_ready = b;
      if (b && r < v.rows) begin
        if (v.op == OP_ACCUM) begin
          for (int c = 0; c < NC; c++) begin
            e.cyc = cyc + c;
            e.val = (v.base + r) % NAR;
            wq[c].push_back(e);
          end
        end else if (v.op == OP_DRAIN) begin
          e.cyc = cyc;
          e.val = (v.base + r) % NAR;
          rq.push_back(e);
          e.cyc = cyc + 1;
          e.val = r;
          oq.push_back(e);
        end
        r++;
      end
      @(negedge clk);
      if (done) begin
        got = 1;
        chk($sformatf("done_lat_v%0d", idx), cyc - s, v.lat);
      end
    end
    if (got == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout_v%0d: got none want %0d",
               idx, v.lat);
    end
    @(posedge clk); #1;
    start = 1'b0;
    sa_valid = 1'b0;
    drain_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("done_pulse_v%0d", idx), int'(done), 0);
    chk($sformatf("ready_after_v%0d", idx), int'(ready), 1);
    chk($sformatf("sb_empty_v%0d", idx), pending(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    int bad;
    vt[0]  = '{OP_CLEAR, 0,    0,   32'h0,        2,   1'b0};
    vt[1]  = '{OP_ACCUM, 8,    4,   32'hFFFFFFFF, 20,  1'b0};
    vt[2]  = '{OP_ACCUM, 100,  3,   32'h0000000D, 20,  1'b0};
    vt[3]  = '{OP_DRAIN, 1022, 4,   32'h0000001D, 6,   1'b0};
    vt[4]  = '{OP_ACCUM, 0,    0,   32'hFFFFFFFF, 1,   1'b0};
    vt[5]  = '{OP_DRAIN, 0,    0,   32'hFFFFFFFF, 1,   1'b0};
    vt[6]  = '{OP_RSVD,  0,    5,   32'hFFFFFFFF, 1,   1'b0};
    vt[7]  = '{OP_ACCUM, 1020, 6,   32'hFFFFFFFF, 22,  1'b0};
    vt[8]  = '{OP_DRAIN, 5,    128, 32'hFFFFFFFF, 129, 1'b0};
    vt[9]  = '{OP_ACCUM, 200,  2,   32'hFFFFFFFF, 18,  1'b1};
    vt[10] = '{OP_ACCUM, 300,  128, 32'hFFFFFFFF, 144, 1'b0};
    vt[11] = '{OP_DRAIN, 900,  3,   32'h00000034, 7,   1'b0};

    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    base_addr = '0;
    num_rows = '0;
    sa_valid = 1'b0;
    drain_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_clear", int'(accum_clear), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(|wr_addr), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_row", int'(out_row), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int k = 0; k < 12; k++) run_cmd(vt[k], k);

    // Reset in the middle of an accumulate.
    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    op = OP_ACCUM;
    base_addr = AW'(40);
    num_rows = RW'(10);
    @(posedge clk); #1;
    start = 1'b0;
    sa_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_wr0_row2", int'(wr_en[0]), 1);
    chk("mid_wa0_row2", int'(wr_addr[AW-1:0]), 42);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_ready", int'(ready), 1);
    chk("mid_rst_done", int'(done), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en != '0 || done || rd_en) bad++;
    end
    chk("mid_rst_quiet", bad, 0);
    @(posedge clk); #1;
    sa_valid = 1'b0;
    mon_en = 1'b1;

    run_cmd(vt[1], 12);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
